// File: rtl/periph_bus_pkg.sv
// Shared types and codes for the two-requester peripheral bus arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package periph_bus_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL,
        ST_DONE,
        ST_ERR
    } state_t;

    // Codes driven on send toward the peripheral.
    localparam logic [1:0] SEND_IDLE = 2'b00;
    localparam logic [1:0] SEND_R0   = 2'b01;
    localparam logic [1:0] SEND_R1   = 2'b10;

    // Codes returned on ack; anything other than ACK_OK reads as idle.
    localparam logic [1:0] ACK_IDLE  = 2'b00;
    localparam logic [1:0] ACK_OK    = 2'b01;

    // Send code for the requester with the given index.
    function automatic logic [1:0] send_code(input logic idx);
        return idx ? SEND_R1 : SEND_R0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a registered priority pointer.
// Latency: pick is combinational; pointer updates on the cycle after adv_i.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic       adv_owner_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
    logic ptr_q;

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        win_o = 1'b0;
        if (req_i == 2'b11) begin
            win_o = ptr_q;
        end else if (req_i[1]) begin
            win_o = 1'b1;
        end
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o = win_o ? 2'b10 : 2'b01;
        end
    end

    // Once a transfer finishes, priority goes to the requester that was not served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (adv_i) begin
            ptr_q <= ~adv_owner_i;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Arbitrates two requesters onto one peripheral using a send/ack four-phase handshake.
// Latency: grant/send/dado one cycle after the IDLE sample; done 5 cycles after it with a 1-cycle-ack peripheral.
// Backpressure: requesters wait with req held; a missing ack edge aborts after TIMEOUT_CYCLES with err.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [1:0]        ack,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic              busy,
    output logic [DATA_W-1:0] dado,
    output logic [1:0]        send
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic              owner_q;
    logic [1:0]        grant_q;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [1:0]        send_q;
    logic [DATA_W-1:0] dado_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        arb_gnt;
    logic              arb_win;
    logic              arb_adv;
    logic              ack_ok;
    logic              cnt_expired;

    // Only 01 counts as an accept; every other code is read as idle.
    assign ack_ok      = (ack == ACK_OK);
    assign cnt_expired = (cnt_q == CNT_LAST);

    // The pointer moves exactly once per transfer, as the FSM leaves DONE or ERR.
    assign arb_adv = (state_q == ST_DONE) || ((state_q == ST_ERR) && !ack_ok);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .adv_i       (arb_adv),
        .adv_owner_i (owner_q),
        .gnt_o       (arb_gnt),
        .win_o       (arb_win)
    );

    // Handshake FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            send_q  <= SEND_IDLE;
            dado_q  <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        state_q <= ST_REQ;
                        owner_q <= arb_win;
                        grant_q <= arb_gnt;
                        send_q  <= send_code(arb_win);
                        dado_q  <= arb_win ? data1 : data0;
                        cnt_q   <= '0;
                    end
                end
                ST_REQ: begin
                    // An accept on the final counted cycle still wins over the abort.
                    if (ack_ok) begin
                        state_q <= ST_REL;
                        send_q  <= SEND_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_expired) begin
                        state_q <= ST_ERR;
                        send_q  <= SEND_IDLE;
                        err_q   <= grant_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_REL: begin
                    if (!ack_ok) begin
                        state_q <= ST_DONE;
                        done_q  <= grant_q;
                        cnt_q   <= '0;
                    end else if (cnt_expired) begin
                        state_q <= ST_ERR;
                        err_q   <= grant_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
                ST_ERR: begin
                    // Hold off the next transfer until the peripheral has let go of ack.
                    if (!ack_ok) begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                    send_q  <= SEND_IDLE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign err   = err_q;
    assign send  = send_q;
    assign dado  = dado_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
